// File: rtl/dac_arbiter_pkg.sv
// Shared DAC definitions: SPI word width, command/data field layout and the
// default watchdog width, so every requester builds DAC words the same way.
package dac_arbiter_pkg;

    localparam int DAC_WORD_WID        = 24;
    localparam int DAC_CMD_WID         = 4;
    localparam int DAC_DATA_WID        = 20;
    localparam int DAC_CMD_LSB         = DAC_DATA_WID;
    localparam int TIMEOUT_WID_DEFAULT = 12;

    // Compose a DAC word: command nibble on top, 20-bit data below.
    function automatic logic [DAC_WORD_WID-1:0] dac_pack_word(
        input logic [DAC_CMD_WID-1:0]  cmd,
        input logic [DAC_DATA_WID-1:0] data
    );
        return {cmd, data};
    endfunction

endpackage

// File: rtl/dac_arbiter_if.sv
// Requester-side and spi_master-side signals of the DAC arbiter.
// slave: the arbiter's view; master: the requesters/spi_master (bench) view.
interface dac_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int REQ_SIZ = 2,
    parameter int DAC_WID = 24
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DAC_WID-1:0] req_data;
    logic [NUM_REQ-1:0]         ack;
    logic                       err;
    logic [DAC_WID-1:0]         rdata;
    logic [REQ_SIZ-1:0]         grant_idx;
    logic                       busy;
    logic                       mas_arm;
    logic [DAC_WID-1:0]         mas_to_slave;
    logic                       mas_finished;
    logic [DAC_WID-1:0]         mas_from_slave;

    modport slave (
        input  req, req_data, mas_finished, mas_from_slave,
        output ack, err, rdata, grant_idx, busy, mas_arm, mas_to_slave
    );

    modport master (
        output req, req_data, mas_finished, mas_from_slave,
        input  ack, err, rdata, grant_idx, busy, mas_arm, mas_to_slave
    );
endinterface

// File: rtl/dac_arbiter_rr_select.sv
// Combinational round-robin picker: first requester with req high, searching
// upward from last_idx+1 with wrap. Shared with the ADC arbiter.
module rr_select #(
    parameter int NUM_REQ = 3,
    parameter int REQ_SIZ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_SIZ-1:0] last_idx,
    output logic [REQ_SIZ-1:0] next_idx,
    output logic               valid
);

    logic [REQ_SIZ-1:0] idx;

    // Walk the candidates in priority order; the first hit wins.
    always_comb begin
        valid    = 1'b0;
        next_idx = last_idx;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = REQ_SIZ'((int'(last_idx) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                next_idx = idx;
            end
        end
    end

endmodule

// File: rtl/dac_arbiter.sv
// Round-robin arbiter sharing one DAC spi_master between NUM_REQ requesters.
// One SPI transaction per grant; a watchdog aborts transactions the master
// never finishes. All outputs are registered.
module dac_arbiter
    import dac_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int REQ_SIZ     = 2,
    parameter int DAC_WID     = DAC_WORD_WID,
    parameter int TIMEOUT_WID = TIMEOUT_WID_DEFAULT
) (
    input logic          clk,
    input logic          rst_L,
    dac_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [TIMEOUT_WID-1:0] wdog;
    logic [REQ_SIZ-1:0]     grant_q;
    logic [DAC_WID-1:0]     tx_q;
    logic [DAC_WID-1:0]     rdata_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic                   err_q;
    logic                   busy_q;
    logic                   arm_q;

    logic [REQ_SIZ-1:0]     pick_idx;
    logic                   pick_vld;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .REQ_SIZ (REQ_SIZ)
    ) u_rr_select (
        .req      (bus.req),
        .last_idx (grant_q),
        .next_idx (pick_idx),
        .valid    (pick_vld)
    );

    // Arbitration FSM with watchdog; every output is a register of this block.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= S_IDLE;
            wdog    <= '0;
            grant_q <= REQ_SIZ'(NUM_REQ - 1);
            tx_q    <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        tx_q    <= bus.req_data[pick_idx*DAC_WID +: DAC_WID];
                        wdog    <= '0;
                        arm_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    // A finish on the saturation cycle still counts as success.
                    if (bus.mas_finished) begin
                        rdata_q <= bus.mas_from_slave;
                        err_q   <= 1'b0;
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        arm_q   <= 1'b0;
                        state   <= S_DONE;
                    end else if (&wdog) begin
                        err_q   <= 1'b1;
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        arm_q   <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        wdog    <= wdog + 1'b1;
                    end
                end
                S_DONE: begin
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    arm_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.grant_idx    = grant_q;
    assign bus.busy         = busy_q;
    assign bus.mas_arm      = arm_q;
    assign bus.mas_to_slave = tx_q;

endmodule

// File: tb/tb_dac_arbiter.sv
// Bench for dac_arbiter: directed transactions with a scoreboard of expected
// ack/err/rdata/grant results checked by an independent monitor.
module tb_dac_arbiter;

    localparam int NR = 3;
    localparam int RS = 2;
    localparam int DW = 24;
    localparam int TW = 6;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic          err;
        logic [DW-1:0] rdata;
        logic [RS-1:0] grant;
    } exp_t;

    logic clk;
    logic rst_L;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    dac_arbiter_if #(.NUM_REQ(NR), .REQ_SIZ(RS), .DAC_WID(DW)) bus();

    dac_arbiter #(
        .NUM_REQ     (NR),
        .REQ_SIZ     (RS),
        .DAC_WID     (DW),
        .TIMEOUT_WID (TW)
    ) dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NR-1:0] a, input logic e, input logic [DW-1:0] r,
                        input logic [RS-1:0] g);
        exp_t x;
        x.ack = a; x.err = e; x.rdata = r; x.grant = g;
        sb.push_back(x);
    endtask

    task automatic wait_arm(input logic [DW-1:0] exp_tx, output int n);
        n = 0;
        while (!bus.mas_arm && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("arm_seen", {31'd0, bus.mas_arm}, 32'd1);
        chk("busy_in_arm", {31'd0, bus.busy}, 32'd1);
        chk("tx_word", {8'd0, bus.mas_to_slave}, {8'd0, exp_tx});
    endtask

    task automatic finish_txn(input logic [DW-1:0] w);
        bus.mas_finished   = 1'b1;
        bus.mas_from_slave = w;
        @(posedge clk); #1;
        bus.mas_finished   = 1'b0;
        bus.mas_from_slave = '0;
    endtask

    task automatic serve(input int delay, input logic [DW-1:0] exp_tx, input logic [DW-1:0] w);
        int n;
        wait_arm(exp_tx, n);
        repeat (delay) begin @(posedge clk); #1; end
        finish_txn(w);
    endtask

    // Monitor: pop the scoreboard on every ack and check pulse/gap shape.
    logic prev_ack, prev_arm, had_txn;
    int   low_cnt;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_L) begin
            prev_ack = 1'b0; prev_arm = 1'b0; had_txn = 1'b0; low_cnt = 0;
        end else begin
            if (|bus.ack) begin
                chk("ack_pulse_width", {31'd0, prev_ack}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {29'd0, bus.ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vec",   {29'd0, bus.ack},       {29'd0, e.ack});
                    chk("err_flag",  {31'd0, bus.err},       {31'd0, e.err});
                    chk("rdata",     {8'd0, bus.rdata},      {8'd0, e.rdata});
                    chk("grant_idx", {30'd0, bus.grant_idx}, {30'd0, e.grant});
                end
            end else if (bus.err) begin
                chk("err_without_ack", {31'd0, bus.err}, 32'd0);
            end
            if (bus.mas_arm && !prev_arm && had_txn)
                chk("arm_low_gap", {31'd0, (low_cnt >= 2)}, 32'd1);
            if (bus.mas_arm) begin
                had_txn = 1'b1; low_cnt = 0;
            end else begin
                low_cnt++;
            end
            prev_ack = |bus.ack;
            prev_arm = bus.mas_arm;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int arms;
        n_chk = 0; n_fail = 0;
        rst_L = 1'b0;
        bus.req = '0; bus.req_data = '0;
        bus.mas_finished = 1'b0; bus.mas_from_slave = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_arm",   {31'd0, bus.mas_arm},      32'd0);
        chk("rst_ack",   {29'd0, bus.ack},          32'd0);
        chk("rst_err",   {31'd0, bus.err},          32'd0);
        chk("rst_busy",  {31'd0, bus.busy},         32'd0);
        chk("rst_rdata", {8'd0, bus.rdata},         32'd0);
        chk("rst_tx",    {8'd0, bus.mas_to_slave},  32'd0);
        chk("rst_grant", {30'd0, bus.grant_idx},    32'd2);
        @(negedge clk) rst_L = 1'b1;
        @(posedge clk); #1;

        // Single request, 50-cycle slave
        bus.req_data = {24'h0, 24'h0, 24'h100ABC};
        bus.req = 3'b001;
        push(3'b001, 1'b0, 24'h00F00D, 2'd0);
        wait_arm(24'h100ABC, n);
        chk("arm_latency", n, 32'd1);
        repeat (50) begin @(posedge clk); #1; end
        finish_txn(24'h00F00D);
        bus.req = 3'b000;
        chk("rdata_single", {8'd0, bus.rdata}, 32'h00F00D);
        repeat (3) begin @(posedge clk); #1; end

        // Round robin from reset: 0,1,2,0,1,2
        rst_L = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_L = 1'b1;
        @(posedge clk); #1;
        bus.req_data = {24'h200002, 24'h200001, 24'h200000};
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            push(NR'(1) << (k % 3), 1'b0, 24'hA00000 + 24'(k), RS'(k % 3));
            serve(2 + k, 24'h200000 + 24'(k % 3), 24'hA00000 + 24'(k));
        end
        bus.req = 3'b000;
        repeat (3) begin @(posedge clk); #1; end

        // Timeout on requester 1, then normal service of requester 2
        bus.req = 3'b010;
        push(3'b010, 1'b1, 24'hA00005, 2'd1);
        wait_arm(24'h200001, n);
        n = 0;
        while (bus.ack == '0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", n, 32'd1 << TW);
        chk("arm_low_on_timeout", {31'd0, bus.mas_arm}, 32'd0);
        bus.req = 3'b000;
        repeat (2) begin @(posedge clk); #1; end
        bus.req = 3'b100;
        push(3'b100, 1'b0, 24'h123456, 2'd2);
        serve(5, 24'h200002, 24'h123456);
        bus.req = 3'b000;
        repeat (3) begin @(posedge clk); #1; end

        // Finish on the saturation cycle: success wins
        bus.req = 3'b001;
        push(3'b001, 1'b0, 24'h5A5A5A, 2'd0);
        serve((1 << TW) - 1, 24'h200000, 24'h5A5A5A);
        bus.req = 3'b000;
        repeat (3) begin @(posedge clk); #1; end

        // Asynchronous reset while in ARM
        bus.req_data = {24'h0, 24'h300001, 24'h300000};
        bus.req = 3'b010;
        wait_arm(24'h300001, n);
        repeat (3) begin @(posedge clk); #1; end
        #1 rst_L = 1'b0;
        #1;
        chk("mid_rst_arm",   {31'd0, bus.mas_arm},     32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},        32'd0);
        chk("mid_rst_ack",   {29'd0, bus.ack},         32'd0);
        chk("mid_rst_rdata", {8'd0, bus.rdata},        32'd0);
        chk("mid_rst_grant", {30'd0, bus.grant_idx},   32'd2);
        bus.req = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_L = 1'b1;
        @(posedge clk); #1;
        bus.req = 3'b011;
        push(3'b001, 1'b0, 24'hB00000, 2'd0);
        serve(4, 24'h300000, 24'hB00000);
        bus.req = 3'b010;
        push(3'b010, 1'b0, 24'hB00001, 2'd1);
        serve(4, 24'h300001, 24'hB00001);
        bus.req = 3'b000;
        repeat (3) begin @(posedge clk); #1; end

        // Early drop of req by requester 1 after grant
        bus.req = 3'b010;
        push(3'b010, 1'b0, 24'hC0FFEE, 2'd1);
        wait_arm(24'h300001, n);
        @(posedge clk); #1;
        bus.req = 3'b000;
        repeat (6) begin @(posedge clk); #1; end
        finish_txn(24'hC0FFEE);
        arms = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.mas_arm) arms++;
        end
        chk("no_regrant", arms, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
